// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD block arbiter: FSM state encoding,
// default block size and the requester index assignments.
package sd_arb_pkg;

    // Arbiter FSM states, exported on state_dbg for observation.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    // One SD block is 512 bytes.
    localparam int DEF_BLOCK_BYTES = 512;

    // Requester slots on the req/grant/byte_valid vectors.
    localparam int AUDIO_REQ = 0;
    localparam int IMAGE_REQ = 1;

    // One-hot vector for a requester index.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sd_block_arbiter_rr_grant2.sv
// Two-way round-robin picker. Purely combinational: given the pending
// requests and the index of the requester granted last, return the one-hot
// winner. On a tie the requester that was not granted last wins.
module rr_grant2 (
    input  logic [1:0] req,
    input  logic       last_ptr,
    output logic [1:0] win,
    output logic       win_valid
);

    // Pick the winner; a lone requester always wins immediately.
    always_comb begin
        win       = 2'b00;
        win_valid = 1'b0;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_ptr ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
        win_valid = |req;
    end

endmodule

// File: rtl/sd_block_arbiter.sv
// Shares the single sd_controller read port between the audio streamer
// (requester 0) and the image loader (requester 1). One 512-byte block is
// read per grant; bytes are steered to the granted requester, the end of the
// block is confirmed by the controller returning to ready, and a card that
// never starts a read is abandoned after a timeout.
//
// Request/grant handshake: a requester raises req[i] (level) with its block
// address stable on req_addr<i>, and holds it until it sees block_done[i] or
// err[i]. The arbiter samples req only in IDLE with sd_ready=1, latches the
// address at the grant edge, and keeps grant[i] high from the next cycle
// through the block_done/err cycle inclusive. byte_valid[i] is a one-cycle
// strobe with no back-pressure: the requester must take byte_data when it
// sees it. Dropping req[i] mid-block stops further byte_valid[i] strobes but
// the block still runs to completion and block_done[i] still pulses.
module sd_block_arbiter
    import sd_arb_pkg::*;
#(
    parameter int BLOCK_BYTES    = DEF_BLOCK_BYTES,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic        clk_25mhz,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    output logic [1:0]  grant,
    output logic [1:0]  byte_valid,
    output logic [7:0]  byte_data,
    output logic [1:0]  block_done,
    output logic [1:0]  err,
    output logic        busy,
    input  logic        sd_ready,
    input  logic        sd_byte_available,
    input  logic [7:0]  sd_dout,
    output logic        sd_rd,
    output logic [31:0] sd_addr,
    output logic [1:0]  state_dbg
);

    localparam int CNT_W = $clog2(BLOCK_BYTES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_BLOCK = CNT_W'(BLOCK_BYTES);
    localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_CYCLES - 1);

    // Registered state and outputs.
    arb_state_t        state_q;
    logic              last_ptr_q;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              av_q;
    logic              dropped_q;
    logic [1:0]        grant_q;
    logic [1:0]        byte_valid_q;
    logic [7:0]        byte_data_q;
    logic [1:0]        block_done_q;
    logic [1:0]        err_q;
    logic              busy_q;
    logic              sd_rd_q;
    logic [31:0]       sd_addr_q;

    // Next-state values.
    arb_state_t        state_n;
    logic              last_ptr_n;
    logic [CNT_W-1:0]  byte_cnt_n;
    logic [TO_W-1:0]   to_cnt_n;
    logic              dropped_n;
    logic [1:0]        grant_n;
    logic [1:0]        byte_valid_n;
    logic [7:0]        byte_data_n;
    logic [1:0]        block_done_n;
    logic [1:0]        err_n;
    logic              busy_n;
    logic              sd_rd_n;
    logic [31:0]       sd_addr_n;

    // Helper terms.
    logic [1:0]        win;
    logic              win_valid;
    logic              byte_event;
    logic              req_lost;
    logic              finishing;

    rr_grant2 u_rr (
        .req       (req),
        .last_ptr  (last_ptr_q),
        .win       (win),
        .win_valid (win_valid)
    );

    // A byte is a rising edge of byte_available; a long-held level is one byte.
    assign byte_event = sd_byte_available & ~av_q;
    // The granted requester no longer wants its data.
    assign req_lost   = ((req & grant_q) == 2'b00);
    // The done/err pulse cycle: grant is still shown, but no new grant yet.
    assign finishing  = (|block_done_q) | (|err_q);

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_n      = state_q;
        last_ptr_n   = last_ptr_q;
        byte_cnt_n   = byte_cnt_q;
        to_cnt_n     = to_cnt_q;
        dropped_n    = dropped_q;
        grant_n      = grant_q;
        byte_valid_n = 2'b00;
        byte_data_n  = byte_data_q;
        block_done_n = 2'b00;
        err_n        = 2'b00;
        sd_addr_n    = sd_addr_q;

        if (finishing) begin
            grant_n = 2'b00;
        end

        if (state_q != IDLE && req_lost) begin
            dropped_n = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Ready gating also drops stale bytes left over from a reset.
                if (!finishing && sd_ready && win_valid) begin
                    state_n    = ISSUE;
                    grant_n    = win;
                    last_ptr_n = win[1];
                    sd_addr_n  = win[1] ? req_addr1 : req_addr0;
                    byte_cnt_n = '0;
                    to_cnt_n   = '0;
                    dropped_n  = 1'b0;
                end
            end
            ISSUE: begin
                if (!sd_ready) begin
                    state_n = XFER;
                end else if (to_cnt_q == TO_LIMIT) begin
                    state_n = IDLE;
                    err_n   = grant_q;
                end else begin
                    to_cnt_n = to_cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (byte_event && byte_cnt_q < FULL_BLOCK) begin
                    byte_cnt_n  = byte_cnt_q + 1'b1;
                    byte_data_n = sd_dout;
                    if (!dropped_q && !req_lost) begin
                        byte_valid_n = grant_q;
                    end
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sd_ready) begin
                    state_n      = IDLE;
                    block_done_n = grant_q;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        sd_rd_n = (state_n == ISSUE);
        busy_n  = (state_n != IDLE) | (|block_done_n) | (|err_n);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_ptr_q   <= 1'b1;
            byte_cnt_q   <= '0;
            to_cnt_q     <= '0;
            av_q         <= 1'b0;
            dropped_q    <= 1'b0;
            grant_q      <= 2'b00;
            byte_valid_q <= 2'b00;
            byte_data_q  <= 8'h00;
            block_done_q <= 2'b00;
            err_q        <= 2'b00;
            busy_q       <= 1'b0;
            sd_rd_q      <= 1'b0;
            sd_addr_q    <= 32'h0;
        end else begin
            state_q      <= state_n;
            last_ptr_q   <= last_ptr_n;
            byte_cnt_q   <= byte_cnt_n;
            to_cnt_q     <= to_cnt_n;
            av_q         <= sd_byte_available;
            dropped_q    <= dropped_n;
            grant_q      <= grant_n;
            byte_valid_q <= byte_valid_n;
            byte_data_q  <= byte_data_n;
            block_done_q <= block_done_n;
            err_q        <= err_n;
            busy_q       <= busy_n;
            sd_rd_q      <= sd_rd_n;
            sd_addr_q    <= sd_addr_n;
        end
    end

    assign grant      = grant_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign block_done = block_done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign sd_rd      = sd_rd_q;
    assign sd_addr    = sd_addr_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/sd_block_arbiter.md
# sd_block_arbiter

Shares the single SPI `sd_controller` read port between two requesters: the audio streamer (requester 0) and the image/frame loader (requester 1). Each requester asks for one 512-byte block at a 32-bit address. The arbiter grants round-robin, drives `rd` and `address`, and steers the byte stream to the granted requester. It counts bytes, waits for the controller to return to ready, and recovers from a stalled card with a timeout. It sits between the top-level `sd_controller` instance and the `audio_processing` / image loader blocks.

## Interface
Parameters:
- BLOCK_BYTES, 512, bytes per block transfer; counter width is clog2(BLOCK_BYTES)+1.
- TIMEOUT_CYCLES, 2_500_000, max cycles in ISSUE waiting for `sd_ready` to fall (100 ms at 25 MHz).

Ports:
- clk_25mhz  in  1  system clock; same clock as `sd_controller`.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester block request, level; held until that requester's `block_done` or `err`.
- req_addr0  in  32  block address for requester 0, sampled at grant.
- req_addr1  in  32  block address for requester 1, sampled at grant.
- grant  out  2  one-hot; high from grant through the `block_done`/`err` cycle.
- byte_valid  out  2  one-cycle strobe; `byte_data` is valid for the indicated requester.
- byte_data  out  8  registered data byte.
- block_done  out  2  one-cycle pulse when BLOCK_BYTES bytes were delivered and the controller is ready again.
- err  out  2  one-cycle timeout pulse to the granted requester.
- busy  out  1  high in any state other than IDLE.
- sd_ready  in  1  controller `ready`.
- sd_byte_available  in  1  controller `byte_available`.
- sd_dout  in  8  controller `dout`.
- sd_rd  out  1  controller `rd`.
- sd_addr  out  32  controller `address`; held stable from ISSUE through DRAIN.

## Operation
- States:
  - IDLE: grant only when `sd_ready`=1 and `req` is nonzero.
  - ISSUE: `sd_rd`=1; go to XFER when `sd_ready`=0; go to IDLE with an `err` pulse if the timeout counter reaches TIMEOUT_CYCLES-1.
  - XFER: count byte events; after byte BLOCK_BYTES go to DRAIN.
  - DRAIN: `sd_rd`=0; when `sd_ready`=1, pulse `block_done` and go to IDLE.
- Byte event = rising edge of `sd_byte_available` (registered previous-value compare). A level held high for N cycles counts as one byte.
- Byte events outside XFER are ignored.
- Any byte event past BLOCK_BYTES is ignored.
- Arbitration: round-robin with a one-bit last-granted pointer, reset to 1 so requester 0 wins the first tie. A single requester is granted immediately. Simultaneous requests go to the requester that was not granted last.
- At grant, latch the winner's address into `sd_addr` and clear the byte counter.
- If `req` for the granted requester drops mid-block, the transfer still completes. `byte_valid` is suppressed for the rest of the block, and `block_done` still pulses.
- `grant` does not change while `busy`=1.
- Reset, including mid-transfer:
  - All outputs go to 0, state goes to IDLE, the pointer goes to 1, and the counters clear.
  - The controller may still be finishing a read. Re-grant is blocked until `sd_ready`=1, so the stale bytes are dropped.

## Timing
- `req` sampled high in IDLE at cycle N with `sd_ready`=1 → at N+1: `grant`, `sd_rd`=1, `sd_addr` valid, `busy`=1.
- `sd_byte_available` rising at cycle M (sampled) → `byte_valid`/`byte_data` at M+1, for exactly one cycle.
- `byte_data` is `sd_dout` sampled at cycle M.
- `sd_ready` seen high in DRAIN at cycle K → `block_done` at K+1. At K+1 `grant` and `busy` are still high; both are 0 at K+2.
- Earliest next grant is K+2; a back-to-back request costs one idle cycle.
- Timeout counter runs only in ISSUE.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `sd_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, XFER, DRAIN);
  - the BLOCK_BYTES default;
  - the requester index constants AUDIO_REQ=0 and IMAGE_REQ=1.
- Sub-module `rr_grant2`: combinational two-way round-robin pick from `req` and the last-granted pointer. Returns a one-hot winner and a valid flag.
- The FSM, counters and edge detect stay in the top block.

## Test plan
1. Reset, then `req`=2'b01, addr0=32'h0000_0200. Controller model drops ready and emits 512 bytes 0x00..0xFF repeating. Required:
   - `sd_addr`=0x200;
   - 512 `byte_valid[0]` pulses with matching data;
   - one `block_done[0]`;
   - `byte_valid[1]` never asserts.
2. `req`=2'b11 held for three blocks. Required: grants go 0, 1, 0, with addresses alternating correctly and one idle cycle between blocks.
3. TIMEOUT_CYCLES=16, model never drops `sd_ready`. Required:
   - `err[0]` pulses at cycle 16 of ISSUE;
   - `sd_rd` returns to 0;
   - IDLE is re-entered.
4. `sd_byte_available` held high 3 cycles per byte. Required: 512 bytes counted, not 1536.
5. Assert `reset_n`=0 at byte 100 of a transfer, release it, and let the model finish its remaining 412 bytes with ready low. Required:
   - no `byte_valid` during those bytes;
   - the next grant occurs only after `sd_ready`=1.
6. Drop `req[1]` at byte 300. Required: no `byte_valid[1]` after that, and `block_done[1]` still pulses once.
